// File: rtl/alu_seq_core.sv
// ALU responder: add/and/xor complete in one cycle, mul runs an LSB-first
// shift-add over WIDTH cycles and reports completion through done/busy.
module alu_seq_core #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 op_start,
   input  logic [1:0]           operation,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   output logic [2*WIDTH-1:0]   result,
   output logic                 done,
   output logic                 busy
);

   // state   | meaning
   // ST_IDLE | accepting requests; single-cycle ops complete here
   // ST_MUL  | multiply in progress, requests ignored

   localparam int RW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   typedef enum logic {ST_IDLE, ST_MUL} state_t;

   state_t            state_q,  state_d;
   logic [RW-1:0]     result_q, result_d;
   logic              done_q,   done_d;
   logic              busy_q,   busy_d;
   logic [RW-1:0]     mcand_q,  mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [RW-1:0]     acc_q,    acc_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [RW-1:0]     step_sum;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      done_d   = 1'b0;
      busy_d   = busy_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

      case (state_q)
         ST_IDLE: begin
            if (op_start) begin
               case (operation)
                  OP_ADD: begin
                     result_d = RW'(operand_a) + RW'(operand_b);
                     done_d   = 1'b1;
                  end
                  OP_AND: begin
                     result_d = RW'(operand_a & operand_b);
                     done_d   = 1'b1;
                  end
                  OP_XOR: begin
                     result_d = RW'(operand_a ^ operand_b);
                     done_d   = 1'b1;
                  end
                  OP_MUL: begin
                     mcand_d  = RW'(operand_a);
                     mplier_d = operand_b;
                     acc_d    = '0;
                     cnt_d    = '0;
                     busy_d   = 1'b1;
                     state_d  = ST_MUL;
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // Last step: publish the sum directly so done lands on this edge
            if (cnt_q == CW'(WIDTH - 1)) begin
               result_d = step_sum;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core with hand-computed expected values.
module tb_alu_seq_core;

   localparam int WIDTH = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                op_start = 1'b0;
   logic [1:0]          operation = 2'b00;
   logic [WIDTH-1:0]    operand_a = '0;
   logic [WIDTH-1:0]    operand_b = '0;
   logic [2*WIDTH-1:0]  result;
   logic                done;
   logic                busy;

   int n_cmp = 0;
   int n_err = 0;

   alu_seq_core #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_start  (op_start),
      .operation (operation),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .result    (result),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Issues a mul, scrambles the inputs afterwards, and checks busy/hold/done timing.
   task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] prev, input logic [15:0] exp);
      int pulses;
      pulses = 0;
      op_start  = 1'b1;
      operation = 2'b11;
      operand_a = a;
      operand_b = b;
      tick();
      op_start  = 1'b0;
      operation = 2'b00;
      operand_a = ~a;
      operand_b = 8'h5A;
      chk("mul_e0_busy", busy, 1);
      chk("mul_e0_done", done, 0);
      chk("mul_e0_hold", result, prev);
      for (int i = 1; i < WIDTH; i++) begin
         tick();
         if (done) pulses++;
         chk("mul_busy", busy, 1);
         chk("mul_hold", result, prev);
      end
      tick();
      chk("mul_done", done, 1);
      chk("mul_busy_clr", busy, 0);
      chk("mul_result", result, exp);
      tick();
      chk("mul_done_pulse", done, 0);
      chk("mul_early_pulses", pulses, 0);
      chk("mul_result_held", result, exp);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_result", result, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // add with carry out
      op_start = 1'b1; operation = 2'b00; operand_a = 8'hFF; operand_b = 8'hFF;
      tick();
      op_start = 1'b0;
      chk("add_done", done, 1);
      chk("add_result", result, 16'h01FE);
      chk("add_busy", busy, 0);
      tick();
      chk("add_done_clr", done, 0);
      chk("add_hold", result, 16'h01FE);

      // back-to-back and / xor
      op_start = 1'b1; operation = 2'b01; operand_a = 8'hF0; operand_b = 8'h3C;
      tick();
      chk("and_done", done, 1);
      chk("and_result", result, 16'h0030);
      operation = 2'b10; operand_a = 8'hAA; operand_b = 8'h55;
      tick();
      op_start = 1'b0;
      chk("xor_done", done, 1);
      chk("xor_result", result, 16'h00FF);
      tick();
      chk("xor_done_clr", done, 0);

      run_mul(8'hFF, 8'hFF, 16'h00FF, 16'hFE01);

      // mul with an add request held high throughout, including the completion edge
      op_start = 1'b1; operation = 2'b11; operand_a = 8'h0D; operand_b = 8'h0B;
      tick();
      operation = 2'b00; operand_a = 8'h01; operand_b = 8'h01;
      for (int i = 1; i < WIDTH; i++) begin
         tick();
         chk("hold_busy", busy, 1);
         chk("hold_done", done, 0);
         chk("hold_result", result, 16'hFE01);
      end
      tick();
      chk("m13x11_done", done, 1);
      chk("m13x11_result", result, 16'h008F);
      chk("m13x11_busy", busy, 0);
      tick();
      op_start = 1'b0;
      chk("add_after_mul_done", done, 1);
      chk("add_after_mul_result", result, 16'h0002);
      tick();
      chk("add_after_mul_clr", done, 0);

      // reset mid-mul aborts
      op_start = 1'b1; operation = 2'b11; operand_a = 8'h12; operand_b = 8'h34;
      tick();
      op_start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_result", result, 0);
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("abort_no_done", done, 0);
         chk("abort_result_zero", result, 0);
      end

      run_mul(8'h02, 8'h03, 16'h0000, 16'h0006);
      run_mul(8'h00, 8'hAB, 16'h0006, 16'h0000);
      run_mul(8'h80, 8'h02, 16'h0000, 16'h0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Synthesizable ALU responder on the op_start/operation/operand_a/operand_b/result interface that the ALU bus-functional model drives.
- add, and, xor: single-cycle.
- mul: iterative shift-add over WIDTH cycles.
- done/busy outputs let an initiator or scoreboard align each result with its request without fixed-latency guesses.
- Sits in the ALU test environment as the DUV behind the interface bundle.

Parameters:
WIDTH, 8, operand width in bits; result is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock (single clock domain)
rst  input  1  synchronous, active-high reset
op_start  input  1  request strobe, sampled each rising edge
operation  input  2  00=add, 01=and, 10=xor, 11=mul
operand_a  input  WIDTH  first operand, unsigned
operand_b  input  WIDTH  second operand, unsigned
result  output  2*WIDTH  registered result, held until the next completion
done  output  1  one-cycle pulse: result updated this cycle
busy  output  1  high while a mul is in progress

Behaviour:
- Reset: one clock, synchronous, active-high (fixed). While rst=1 at a rising edge:
  - result=0, done=0, busy=0, state=IDLE, internal accumulator/counter/operand latches cleared.
  - rst overrides op_start in the same edge.
- States:
  - IDLE: not busy.
  - MUL: busy=1. No separate DONE state; done is a registered flag.
- Acceptance:
  - op_start is accepted only at an edge where state==IDLE (busy==0).
  - op_start while busy==1 is ignored and not queued.
  - This includes the edge on which the mul completes.
- done:
  - Defaults to 0 every edge.
  - Set to 1 only on the edge a result is written.
- add/and/xor (accepted at edge E0):
  - At E0: result <= zero-extended computation; done <= 1; state stays IDLE.
  - Latency is 1 cycle.
  - add keeps the carry in bit WIDTH; bits above WIDTH are 0.
  - and/xor upper WIDTH bits are 0.
  - Back-to-back: op_start high on consecutive edges yields done high on consecutive cycles, each with its own result.
- mul (accepted at edge E0):
  - At E0: latch a and b, clear accumulator, counter=0, busy<=1, state<=MUL.
  - result and done are unchanged at E0.
  - Edges E1..E_WIDTH: one shift-add step per edge, using LSB-first multiplier bits and a left-shifted multiplicand.
  - At E_WIDTH (final step): result <= full 2*WIDTH product; done <= 1; busy <= 0; state <= IDLE.
  - Latency: done visible WIDTH cycles after acceptance (8 for default).
  - Earliest next acceptance is edge E_WIDTH+1.
  - Operand inputs may change freely after E0 without affecting the product.
- result:
  - Changes only on done edges or reset.
  - Stable otherwise, including throughout a mul.
- Reset mid-mul aborts the operation:
  - No done pulse; result=0.
  - First acceptance is possible on the edge after rst falls.
- No overflow is possible: the product of two WIDTH-bit unsigned values fits in 2*WIDTH bits.
- operation is decoded only at acceptance; changes during MUL are ignored.

Test Plan:
- Reset, then add a=0xFF, b=0xFF -> 1 cycle later done=1, result=0x01FE, busy=0; next cycle done=0 with result held at 0x01FE.
- and 0xF0,0x3C then xor 0xAA,0x55 on consecutive edges -> done high two cycles in a row, result 0x0030 then 0x00FF.
- mul 0xFF,0xFF -> busy=1 for 8 cycles, then done=1, result=0xFE01, busy=0; result unchanged (prior value) during busy.
- mul 0x0D,0x0B followed by op_start=add 0x01,0x01 held high throughout, including the completion edge:
  - done=1 with result=0x008F (143); add is ignored while busy.
  - Add is accepted on the next edge; result=0x0002 one cycle later.
- mul 0x12,0x34 with rst=1 asserted 4 cycles in -> no done pulse, result=0, busy=0.
  - Then mul 0x02,0x03 -> result=0x0006 after 8 cycles.
- mul 0x00,0xAB and mul 0x80,0x02 -> result=0x0000 and 0x0100 respectively, each with exactly one done pulse after 8 cycles.
